// File: rtl/mem_dma.sv
// Byte-wide copy/fill DMA engine driving a single-port memory that samples on negedge clk.
// Every output is registered, so each transition computes the outputs for the state being entered.
module mem_dma #(
  parameter int WIDTH         = 8,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [RAM_ADDR_BITS-1:0] src,
  input  logic [RAM_ADDR_BITS-1:0] dst,
  input  logic [RAM_ADDR_BITS-1:0] len,
  input  logic [WIDTH-1:0]         fill_val,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         sum,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]               state;
  logic                     mode_r;
  logic [RAM_ADDR_BITS-1:0] src_r;
  logic [RAM_ADDR_BITS-1:0] dst_r;
  logic [RAM_ADDR_BITS-1:0] len_r;
  logic [WIDTH-1:0]         fill_r;
  logic [RAM_ADDR_BITS-1:0] idx;
  logic [RAM_ADDR_BITS-1:0] idx_next;
  logic                     accept;

  assign accept   = (state == IDLE) && start;
  assign idx_next = idx + RAM_ADDR_BITS'(1);

  // Job parameters only matter while a job runs, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mode_r <= mode;
      src_r  <= src;
      dst_r  <= dst;
      len_r  <= len;
      fill_r <= fill_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum  <= '0;
            idx  <= '0;
            busy <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (!mode) begin
              state   <= RD;
              mem_en  <= 1'b1;
              mem_we  <= 1'b0;
              mem_adr <= src;
            end else begin
              state     <= WR;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_adr   <= dst;
              mem_wdata <= fill_val;
            end
          end
        end
        RD: begin
          // Read data lands directly in the write-data register for the following WR cycle.
          state     <= WR;
          mem_we    <= 1'b1;
          mem_adr   <= dst_r + idx;
          mem_wdata <= mem_rdata;
        end
        WR: begin
          sum <= sum + mem_wdata;
          idx <= idx_next;
          if (idx_next == len_r) begin
            state  <= DONE;
            done   <= 1'b1;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else if (!mode_r) begin
            state   <= RD;
            mem_we  <= 1'b0;
            mem_adr <= src_r + idx_next;
          end else begin
            mem_adr   <= dst_r + idx_next;
            mem_wdata <= fill_r;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: table of jobs checked against a reference memory model, plus
// hand-written sequences for start-while-busy and reset mid-job.
module tb_mem_dma;

  logic       clk;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic [7:0] fill_val;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_adr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  mem_dma #(.WIDTH(8), .RAM_ADDR_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .sum(sum),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] fv;
    logic [7:0] sum;
    int         cyc;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   en_cnt = 0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  wr_t  exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: samples on negedge; writes are popped from the scoreboard.
  always @(negedge clk) begin
    if (mem_we && !mem_en) check("we_without_en", 1, 0);
    if (mem_en) begin
      en_cnt++;
      if (mem_we) begin
        mem[mem_adr] = mem_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_write_adr", {24'd0, mem_adr}, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("write_adr", {24'd0, mem_adr}, {24'd0, w.a});
          check("write_data", {24'd0, mem_wdata}, {24'd0, w.d});
        end
      end else begin
        mem_rdata = mem[mem_adr];
      end
    end
  end

  // Reference: ascending byte-by-byte transfer over ref_mem, first nbytes bytes only.
  task automatic model_job(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input int nbytes, input logic [7:0] fv);
    for (int k = 0; k < nbytes; k++) begin
      logic [7:0] a;
      logic [7:0] v;
      a = d + 8'(k);
      v = m ? fv : ref_mem[8'(s + 8'(k))];
      ref_mem[a] = v;
      exp_q.push_back('{a: a, d: v});
    end
  endtask

  task automatic drive_job(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] fv);
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = fv;
  endtask

  task automatic run_job(input string name, input vec_t v, input int poke);
    int c;
    int en0;
    model_job(v.mode, v.src, v.dst, int'(v.len), v.fv);
    en0 = en_cnt;
    drive_job(v.mode, v.src, v.dst, v.len, v.fv);
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    check({name, "_busy_c1"}, {31'd0, busy}, 1);
    while (!done && c < 600) begin
      if (c == poke) drive_job(1'b0, 8'h00, 8'h11, 8'h01, 8'h5A);
      else start = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    check({name, "_done_cycle"}, c, v.cyc);
    check({name, "_sum"}, {24'd0, sum}, {24'd0, v.sum});
    check({name, "_busy_in_done"}, {31'd0, busy}, 1);
    check({name, "_en_in_done"}, {31'd0, mem_en}, 0);
    @(posedge clk); #1;
    check({name, "_done_pulse_end"}, {31'd0, done}, 0);
    check({name, "_idle_busy"}, {31'd0, busy}, 0);
    check({name, "_sum_hold"}, {24'd0, sum}, {24'd0, v.sum});
    check({name, "_en_cycles"}, en_cnt - en0,
          v.mode ? int'(v.len) : 2 * int'(v.len));
    check({name, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, {31'd0, busy}, 0);
    check({name, "_done"}, {31'd0, done}, 0);
    check({name, "_sum"}, {24'd0, sum}, 0);
    check({name, "_en"}, {31'd0, mem_en}, 0);
    check({name, "_we"}, {31'd0, mem_we}, 0);
    check({name, "_adr"}, {24'd0, mem_adr}, 0);
    check({name, "_wdata"}, {24'd0, mem_wdata}, 0);
  endtask

  vec_t tbl [8];

  initial begin
    int   bad_bytes;
    logic saw_done;
    vec_t rv;

    //            mode  src    dst    len    fill   sum    cycle of done
    tbl[0] = '{1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 8'h94, 5};  // fill
    tbl[1] = '{1'b0, 8'h00, 8'h80, 8'd3, 8'h00, 8'h06, 7};  // copy 01,02,03
    tbl[2] = '{1'b1, 8'h00, 8'hFE, 8'd3, 8'h11, 8'h33, 4};  // fill wraps FE,FF,00
    tbl[3] = '{1'b0, 8'h00, 8'h40, 8'd0, 8'h00, 8'h00, 1};  // len 0
    tbl[4] = '{1'b0, 8'h20, 8'h21, 8'd4, 8'h00, 8'h84, 9};  // overlap propagates 21
    tbl[5] = '{1'b0, 8'hFE, 8'h40, 8'd3, 8'h00, 8'h33, 7};  // copy src wraps, reads 11s
    tbl[6] = '{1'b1, 8'h00, 8'h70, 8'd1, 8'hFF, 8'hFF, 2};  // single-byte fill
    tbl[7] = '{1'b1, 8'h00, 8'hC0, 8'd4, 8'h3C, 8'hF0, 5};  // fill with start poke

    for (int k = 0; k < 256; k++) begin
      mem[k] = 8'(k + 1);
      ref_mem[k] = 8'(k + 1);
    end

    reset = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
    repeat (2) @(posedge clk);
    // Reset must win over a simultaneous start.
    #1 drive_job(1'b1, 8'h00, 8'h30, 8'd2, 8'h77);
    @(posedge clk); #1;
    check_reset_outputs("reset");
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_stays_idle", {31'd0, busy}, 0);

    for (int t = 0; t < 7; t++) run_job($sformatf("vec%0d", t), tbl[t], -1);
    run_job("start_while_busy", tbl[7], 2);

    // Reset during the second WR of a 5-byte copy: only two writes reach memory.
    model_job(1'b0, 8'h50, 8'h58, 2, 8'h00);
    drive_job(1'b0, 8'h50, 8'h58, 8'd5, 8'h00);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_in_wr2_we", {31'd0, mem_we}, 1);
    check("abort_in_wr2_adr", {24'd0, mem_adr}, 32'h59);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("abort");
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy || mem_en) saw_done = 1'b1;
    end
    check("abort_no_activity", {31'd0, saw_done}, 0);
    check("abort_writes_left", exp_q.size(), 0);

    rv = '{1'b0, 8'h50, 8'h90, 8'd2, 8'h00, 8'hA3, 5};  // 0x51+0x52
    run_job("after_abort", rv, -1);

    bad_bytes = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) bad_bytes++;
    check("final_memory_image", bad_bytes, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
